// File: rtl/surf5_wbarb_pkg.sv
// surf5_wbarb_pkg
//   Shared definitions for the SURF5 internal WISHBONE arbiter:
//   FSM state encoding and the internal bus widths (20-bit address,
//   32-bit data).
package surf5_wbarb_pkg;

  localparam int WB_ADR_W = 20;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN    = 2'd1,
    ST_LOCKED = 2'd2
  } wbarb_state_t;

endpackage

// File: rtl/surf5_rr_pick.sv
// surf5_rr_pick
//   Combinational round-robin priority encoder. The search starts at
//   (last_i + 1) mod N and wraps, so the previous owner has the lowest
//   priority.
// Ports:
//   req_i   [N-1:0]   request vector
//   last_i  [IW-1:0]  index of the previous owner
//   gnt_o   [N-1:0]   one-hot winner (all zero when nothing requests)
//   idx_o   [IW-1:0]  index of the winner (0 when nothing requests)
module surf5_rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  // One extra bit so last_i + N cannot overflow before the wrap.
  localparam int SW = IW + 1;

  logic [SW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, last_i} + SW'(off);
      if (cand >= SW'(N)) cand = cand - SW'(N);
      if (!found && req_i[cand[IW-1:0]]) begin
        found                = 1'b1;
        gnt_o[cand[IW-1:0]]  = 1'b1;
        idx_o                = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/surf5_wb_arbiter.sv
// surf5_wb_arbiter
//   Shares the single internal WISHBONE bus among NMASTERS masters
//   (VIO bridge, PCI/host bridge, housekeeping sequencer). The grant is
//   registered round-robin; a master holding m_lock_i across a cyc drop
//   keeps the bus (LOCKED) so read-modify-write sequences are atomic.
//
// Handshake: a master owns the bus from the clock after grant until it
//   drops cyc. While owned, cyc/stb/we/adr/dat are a combinational mux of
//   the owner's inputs, and ack/err/rty reach only the owner. stb without
//   cyc never reaches the slave. Read data is broadcast to all masters.
//
// Ports:
//   clk_i, rst_n_i                    clock, async active-low reset
//   m_cyc_i/m_stb_i/m_we_i/m_lock_i   per-master controls [NMASTERS]
//   m_adr_i / m_dat_i                 packed, master k at [20k +: 20] / [32k +: 32]
//   m_dat_o, m_ack_o/m_err_o/m_rty_o  read data (broadcast), routed terminations
//   cyc_o/stb_o/we_o/adr_o/dat_o      slave-side request
//   dat_i, ack_i/err_i/rty_i          slave-side response
//   grant_o                           one-hot current owner
//   state_o                           FSM state (debug tap)
//   timeout_o                         sticky watchdog flag (SURF5_WBARB_TIMEOUT_EN only)
//
// Optional feature, macro SURF5_WBARB_TIMEOUT_EN: a watchdog aborts an
//   owned cycle that sees no termination for TIMEOUT clocks, pulsing err
//   to the owner and returning to IDLE even if lock is held.
module surf5_wb_arbiter
  import surf5_wbarb_pkg::*;
#(
  parameter int NMASTERS = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [NMASTERS-1:0]          m_cyc_i,
  input  logic [NMASTERS-1:0]          m_stb_i,
  input  logic [NMASTERS-1:0]          m_we_i,
  input  logic [NMASTERS-1:0]          m_lock_i,
  input  logic [WB_ADR_W*NMASTERS-1:0] m_adr_i,
  input  logic [WB_DAT_W*NMASTERS-1:0] m_dat_i,
  output logic [WB_DAT_W-1:0]          m_dat_o,
  output logic [NMASTERS-1:0]          m_ack_o,
  output logic [NMASTERS-1:0]          m_err_o,
  output logic [NMASTERS-1:0]          m_rty_o,
  output logic                         cyc_o,
  output logic                         stb_o,
  output logic                         we_o,
  output logic [WB_ADR_W-1:0]          adr_o,
  output logic [WB_DAT_W-1:0]          dat_o,
  input  logic [WB_DAT_W-1:0]          dat_i,
  input  logic                         ack_i,
  input  logic                         err_i,
  input  logic                         rty_i,
  output logic [NMASTERS-1:0]          grant_o,
`ifdef SURF5_WBARB_TIMEOUT_EN
  output logic                         timeout_o,
`endif
  output logic [1:0]                   state_o
);

  localparam int IW = $clog2(NMASTERS);

  if (NMASTERS < 2 || NMASTERS > 4 || TIMEOUT < 1) begin : g_bad_params
    $error("surf5_wb_arbiter: NMASTERS must be 2..4 and TIMEOUT >= 1");
  end

  wbarb_state_t        state_q, state_d;
  logic [NMASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_q, last_d;
  logic [NMASTERS-1:0] pick_gnt;
  logic [IW-1:0]       pick_idx;
  logic                owner_cyc;
  logic                owner_lock;
  logic                tmo_hit;

  surf5_rr_pick #(
    .N  (NMASTERS),
    .IW (IW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  assign owner_cyc  = m_cyc_i[owner_q];
  assign owner_lock = m_lock_i[owner_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          state_d = ST_OWN;
          grant_d = pick_gnt;
          owner_d = pick_idx;
        end
      end
      ST_OWN: begin
        // The watchdog overrides lock: a hung slave must free the bus.
        if (tmo_hit || (!owner_cyc && !owner_lock)) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end else if (!owner_cyc) begin
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        if (owner_cyc) begin
          state_d = ST_OWN;
        end else if (!owner_lock) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IW'(NMASTERS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Slave side is only driven in OWN; reset forces IDLE so the bus drops
  // asynchronously with no termination reaching any master.
  always_comb begin
    cyc_o   = 1'b0;
    stb_o   = 1'b0;
    we_o    = 1'b0;
    adr_o   = '0;
    dat_o   = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == ST_OWN) begin
      cyc_o   = owner_cyc & ~tmo_hit;
      stb_o   = owner_cyc & m_stb_i[owner_q] & ~tmo_hit;
      we_o    = m_we_i[owner_q];
      adr_o   = m_adr_i[int'(owner_q)*WB_ADR_W +: WB_ADR_W];
      dat_o   = m_dat_i[int'(owner_q)*WB_DAT_W +: WB_DAT_W];
      m_ack_o = grant_q & {NMASTERS{ack_i}};
      m_err_o = grant_q & {NMASTERS{err_i | tmo_hit}};
      m_rty_o = grant_q & {NMASTERS{rty_i}};
    end
  end

  assign m_dat_o = dat_i;
  assign grant_o = grant_q;
  assign state_o = state_q;

`ifdef SURF5_WBARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] tmo_cnt_q;
  logic          timeout_q;
  logic          term_any;

  assign term_any = ack_i | err_i | rty_i;
  // The counter holds the number of terminated-free OWN clocks already
  // elapsed, so the TIMEOUT-th such clock is the one that aborts.
  assign tmo_hit  = (state_q == ST_OWN) && owner_cyc && !term_any &&
                    (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d == ST_OWN && state_q != ST_OWN) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_OWN && term_any) begin
        tmo_cnt_q <= '0;
      end else if (state_q == ST_OWN && cyc_o) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign tmo_hit = 1'b0;
`endif

endmodule

// File: doc/surf5_wb_arbiter.md
Name: surf5_wb_arbiter

Overview:
- Shares the single internal WISHBONE bus (32-bit data, 20-bit address) among several masters.
- Masters include the VIO debug bridge, the PCI/host bridge and the housekeeping sequencer.
- Registered round-robin grant with bus-lock support, so a multi-cycle read-modify-write from one master is never interleaved with another.
- Sits between the masters and the address decoder/slave fabric, on the WISHBONE control clock.

Parameters:
- NMASTERS, 3, number of requesting masters (2..4).
- TIMEOUT, 255, watchdog limit in clocks for a granted cycle without ack/err/rty (valid only with the optional feature).

Ports:
- clk_i  in  1  WISHBONE control clock.
- rst_n_i  in  1  asynchronous active-low reset.
- m_cyc_i  in  NMASTERS  per-master cyc.
- m_stb_i  in  NMASTERS  per-master stb.
- m_we_i  in  NMASTERS  per-master we.
- m_lock_i  in  NMASTERS  per-master lock request.
- m_adr_i  in  20*NMASTERS  packed addresses; master k at [20k +: 20].
- m_dat_i  in  32*NMASTERS  packed write data.
- m_dat_o  out  32  slave read data, broadcast to all masters.
- m_ack_o  out  NMASTERS  ack, routed to the granted master only.
- m_err_o  out  NMASTERS  err, routed to the granted master only.
- m_rty_o  out  NMASTERS  rty, routed to the granted master only.
- cyc_o, stb_o, we_o  out  1  slave-side controls.
- adr_o  out  20  slave-side address.
- dat_o  out  32  slave-side write data.
- dat_i  in  32  slave read data.
- ack_i, err_i, rty_i  in  1  slave terminations.
- grant_o  out  NMASTERS  one-hot current owner, for debug taps.

Behaviour:
- Reset: asynchronous on rst_n_i low. State IDLE, grant_o=0, last-owner pointer=NMASTERS-1.
- Outputs during reset: cyc_o=stb_o=we_o=0, adr_o=dat_o=0, all m_ack_o/m_err_o/m_rty_o=0.
- Reset mid-cycle: bus dropped immediately, no termination returned to any master.
- States: IDLE, OWN, LOCKED.
- IDLE:
  - If any m_cyc_i is high, grant the first requester searching from (last owner + 1) mod NMASTERS upward with wrap. Go to OWN.
  - grant_o is registered, so there is 1 clock from m_cyc_i to cyc_o.
- OWN:
  - Slave controls (cyc, stb, we, adr, dat) are a combinational mux of the owner's inputs.
  - ack_i/err_i/rty_i are ANDed with the owner's grant bit. Non-owners always see 0.
  - m_dat_o = dat_i unconditionally.
  - When the owner drops m_cyc_i:
    - if m_lock_i is high in that same clock, go to LOCKED;
    - otherwise record the owner as last owner and go to IDLE.
  - No re-arbitration occurs while the owner keeps cyc high, whatever the other requests.
- LOCKED:
  - cyc_o=stb_o=0; grant held.
  - Owner cyc high again → OWN with no extra latency cycle.
  - Owner lock low with cyc low → IDLE, last owner updated.
- Simultaneous requests in IDLE resolve by round-robin only. After owner k releases, owner k+1 wins if it is requesting.
- A master raising stb without cyc is ignored.
- IDLE→OWN→IDLE→OWN for the same master costs one dead clock between cycles. This is accepted.
- Width rules: packed vectors are indexed LSB-first, so master 0 occupies bits [19:0] / [31:0].

Optional Feature:
- Macro: SURF5_WBARB_TIMEOUT_EN.
- With it defined:
  - An 8-bit-or-wider counter clears on entering OWN and on each slave termination.
  - It increments each OWN clock with cyc_o high.
  - On reaching TIMEOUT:
    - m_err_o is pulsed for 1 clock to the owner;
    - cyc_o/stb_o are forced low that clock;
    - state goes to IDLE regardless of lock;
    - a sticky timeout_o output (1 bit) is set, cleared only by reset.
- Without it: no counter, no timeout_o port, and a hung slave holds the bus indefinitely.

Decomposition:
- Package surf5_wbarb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_OWN=2'd1, ST_LOCKED=2'd2;
  - WB_ADR_W=20 and WB_DAT_W=32.
- One sub-module, surf5_rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector and last-owner index.
  - Outputs: one-hot grant and its index.
  - Shared with the planned trigger-readout arbiter.

Test Plan:
- Single master: master 1 reads adr 0x00010 with NMASTERS=3; slave acks 2 clocks later with 0xDEADBEEF.
  → cyc_o rises 1 clock after m_cyc_i[1]; m_ack_o=3'b010 for 1 clock; m_dat_o=0xDEADBEEF.
- Contention: all three masters raise cyc in the same clock from reset, each releasing after its ack.
  → grant order 0,1,2; then with master 0 requesting again → 0; grant_o never multi-hot.
- Lock: master 2 does a lock=1 read, drops cyc, master 0 requests, then master 2 writes 0x5 and drops lock.
  → master 0 receives no grant until master 2's lock is low; master 2's write passes straight to OWN.
- Termination routing: slave returns err_i and rty_i for master 1.
  → only m_err_o[1] / m_rty_o[1] assert; the other bits stay 0.
- Reset mid-cycle: rst_n_i pulsed low while master 0 owns with cyc_o high.
  → cyc_o=0 asynchronously, grant_o=0; the next request from master 0 is granted 1 clock after rst_n_i release.
- With SURF5_WBARB_TIMEOUT_EN and TIMEOUT=16: the slave never acks.
  → m_err_o[owner] pulses at the 16th OWN clock, timeout_o=1, the arbiter returns to IDLE and grants the next requester.
